latch_regfile_mp: RTL and testbench



---
 rtl/latch_regfile_mp.sv | 108 ++++++++++
 tb/tb_latch_regfile_mp.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/latch_regfile_mp.sv
// Multi-ported latch-based register file. Writes are sampled into flops at the
// rising edge and land in the addressed entry latch during the following high phase.
module latch_regfile_mp #(
  parameter int unsigned           DATA_WIDTH     = 32,
  parameter int unsigned           ADDR_WIDTH     = 5,
  parameter int unsigned           NR_READ_PORTS  = 2,
  parameter int unsigned           NR_WRITE_PORTS = 1,
  parameter bit                    ZERO_REG_ZERO  = 1'b1,
  parameter logic [DATA_WIDTH-1:0] INIT           = '0
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  test_en_i,
  input  logic [NR_READ_PORTS*ADDR_WIDTH-1:0]   raddr_i,
  output logic [NR_READ_PORTS*DATA_WIDTH-1:0]   rdata_o,
  input  logic [NR_WRITE_PORTS*ADDR_WIDTH-1:0]  waddr_i,
  input  logic [NR_WRITE_PORTS*DATA_WIDTH-1:0]  wdata_i,
  input  logic [NR_WRITE_PORTS-1:0]             we_i
);

  localparam int unsigned NUM_ENTRIES = 1 << ADDR_WIDTH;

  logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0] wdata_q;
  logic [NR_WRITE_PORTS-1:0][ADDR_WIDTH-1:0] waddr_q;
  logic [NR_WRITE_PORTS-1:0]                 we_q;

  logic [DATA_WIDTH-1:0] mem [NUM_ENTRIES];

  // Stage 1: capture write data/address only on an enabled port; the enable is
  // sampled every cycle so a stale address can never trigger a second write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wdata_q <= '0;
      waddr_q <= '0;
      we_q    <= '0;
    end else begin
      we_q <= we_i;
      for (int p = 0; p < int'(NR_WRITE_PORTS); p++) begin
        if (we_i[p]) begin
          wdata_q[p] <= wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
          waddr_q[p] <= waddr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
        end
      end
    end
  end

  for (genvar i = 0; i < int'(NUM_ENTRIES); i++) begin : g_entry
    if (ZERO_REG_ZERO && (i == 0)) begin : g_zero
      assign mem[i] = '0;
    end else begin : g_latch
      logic                  en_d;
      logic                  en_q;
      logic                  gclk;
      logic                  hit;
      logic [DATA_WIDTH-1:0] wsel;
      logic [DATA_WIDTH-1:0] q;

      always_comb begin
        en_d = 1'b0;
        for (int p = 0; p < int'(NR_WRITE_PORTS); p++) begin
          if (we_i[p] && (waddr_i[p*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(i))) begin
            en_d = 1'b1;
          end
        end
      end

      // Ascending scan: the highest-index port that hits this entry wins.
      always_comb begin
        hit  = 1'b0;
        wsel = '0;
        for (int p = 0; p < int'(NR_WRITE_PORTS); p++) begin
          if (we_q[p] && (waddr_q[p] == ADDR_WIDTH'(i))) begin
            hit  = 1'b1;
            wsel = wdata_q[p];
          end
        end
      end

      // Clock-gate enable latch: transparent only while the clock is low.
      always_latch begin
        if (!rst_ni) begin
          en_q <= 1'b0;
        end else if (!clk_i) begin
          en_q <= en_d | test_en_i;
        end
      end

      assign gclk = clk_i & en_q;

      // With no hit the entry keeps its value, which is what recirculating its
      // own output through the input mux would produce when the gate is forced open.
      always_latch begin
        if (!rst_ni) begin
          q <= INIT;
        end else if (gclk && hit) begin
          q <= wsel;
        end
      end

      assign mem[i] = q;
    end
  end

  for (genvar r = 0; r < int'(NR_READ_PORTS); r++) begin : g_read
    assign rdata_o[r*DATA_WIDTH +: DATA_WIDTH] = mem[raddr_i[r*ADDR_WIDTH +: ADDR_WIDTH]];
  end

endmodule

// File: tb/tb_latch_regfile_mp.sv
// Directed bench for latch_regfile_mp: a hardwired-zero 2R/2W instance and a
// plain 1R/1W instance driven from one linear sequence of steps.
module tb_latch_regfile_mp;

  logic clk;
  logic rst_n;
  logic test_en;

  // Instance 0: 32 entries, 2 read, 2 write, entry 0 hardwired, INIT DEADBEEF
  logic [9:0]  raddr0;
  logic [63:0] rdata0;
  logic [9:0]  waddr0;
  logic [63:0] wdata0;
  logic [1:0]  we0;

  // Instance 1: 8 entries, 1 read, 1 write, entry 0 writable, INIT 0
  logic [2:0]  raddr1;
  logic [31:0] rdata1;
  logic [2:0]  waddr1;
  logic [31:0] wdata1;
  logic [0:0]  we1;

  int n_checks = 0;
  int n_fail   = 0;

  latch_regfile_mp #(
    .DATA_WIDTH(32), .ADDR_WIDTH(5), .NR_READ_PORTS(2), .NR_WRITE_PORTS(2),
    .ZERO_REG_ZERO(1'b1), .INIT(32'hDEAD_BEEF)
  ) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .test_en_i(test_en),
    .raddr_i(raddr0), .rdata_o(rdata0),
    .waddr_i(waddr0), .wdata_i(wdata0), .we_i(we0)
  );

  latch_regfile_mp #(
    .DATA_WIDTH(32), .ADDR_WIDTH(3), .NR_READ_PORTS(1), .NR_WRITE_PORTS(1),
    .ZERO_REG_ZERO(1'b0), .INIT(32'h0)
  ) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .test_en_i(test_en),
    .raddr_i(raddr1), .rdata_o(rdata1),
    .waddr_i(waddr1), .wdata_i(wdata1), .we_i(we1)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected end of sequence");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one full cycle; returns in the low phase, where inputs are driven.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n   = 1'b0;
    test_en = 1'b0;
    raddr0  = '0; waddr0 = '0; wdata0 = '0; we0 = '0;
    raddr1  = '0; waddr1 = '0; wdata1 = '0; we1 = '0;

    // Reset contents
    repeat (2) @(negedge clk);
    raddr0 = {5'd5, 5'd0};
    #1;
    check("rst_p0_addr0", rdata0[31:0], 32'h0000_0000);
    check("rst_p1_addr5", rdata0[63:32], 32'hDEAD_BEEF);
    raddr0 = {5'd5, 5'd5};
    #1;
    check("rst_p0_addr5", rdata0[31:0], 32'hDEAD_BEEF);
    check("rst_p1_addr5b", rdata0[63:32], 32'hDEAD_BEEF);
    check("rst_d1_addr0", rdata1, 32'h0000_0000);
    rst_n = 1'b1;
    tick();

    // Single write: old value in the write cycle, new value one cycle later
    we0 = 2'b01; waddr0[4:0] = 5'd3; wdata0[31:0] = 32'h1234_5678;
    raddr0 = {5'd3, 5'd3};
    #1;
    check("wr3_same_cycle", rdata0[31:0], 32'hDEAD_BEEF);
    tick();
    we0 = 2'b00;
    #1;
    check("wr3_next_p0", rdata0[31:0], 32'h1234_5678);
    check("wr3_next_p1", rdata0[63:32], 32'h1234_5678);

    // Both ports hit address 7: port 1 wins
    we0 = 2'b11; waddr0 = {5'd7, 5'd7}; wdata0 = {32'h5A5A_5A5A, 32'hA5A5_A5A5};
    raddr0 = {5'd3, 5'd7};
    #1;
    check("prio_same_cycle", rdata0[31:0], 32'hDEAD_BEEF);
    tick();
    we0 = 2'b00;
    #1;
    check("prio_addr7", rdata0[31:0], 32'h5A5A_5A5A);
    check("prio_keep3", rdata0[63:32], 32'h1234_5678);

    // Both ports to distinct addresses in one cycle
    we0 = 2'b11; waddr0 = {5'd11, 5'd10}; wdata0 = {32'h2222_2222, 32'h1111_1111};
    tick();
    we0 = 2'b00; raddr0 = {5'd11, 5'd10};
    #1;
    check("dual_addr10", rdata0[31:0], 32'h1111_1111);
    check("dual_addr11", rdata0[63:32], 32'h2222_2222);

    // Writes to entry 0: dropped when hardwired, stored otherwise
    we0 = 2'b10; waddr0 = {5'd0, 5'd0}; wdata0 = {32'hFFFF_FFFF, 32'h0};
    we1 = 1'b1; waddr1 = 3'd0; wdata1 = 32'hFFFF_FFFF;
    tick();
    we0 = 2'b00; we1 = 1'b0; raddr0 = {5'd0, 5'd0}; raddr1 = 3'd0;
    #1;
    check("zero_hardwired", rdata0[31:0], 32'h0000_0000);
    check("zero_writable", rdata1, 32'hFFFF_FFFF);
    raddr1 = 3'd1;
    #1;
    check("zero_writable_nb", rdata1, 32'h0000_0000);

    // Load entries 1..31 with their index, then hold test_en for 10 cycles
    for (int i = 1; i < 32; i++) begin
      we0 = 2'b01; waddr0[4:0] = i[4:0]; wdata0[31:0] = 32'(i);
      tick();
    end
    we0 = 2'b00;
    test_en = 1'b1;
    repeat (10) tick();
    test_en = 1'b0;
    for (int i = 0; i < 32; i++) begin
      raddr0 = {i[4:0], i[4:0]};
      #1;
      check("test_en_p0", rdata0[31:0], 32'(i));
      check("test_en_p1", rdata0[63:32], 32'(i));
    end

    // Reset asserted within the write cycle: the write is lost
    we0 = 2'b01; waddr0[4:0] = 5'd9; wdata0[31:0] = 32'h0000_00AA;
    raddr0 = {5'd5, 5'd9};
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid_addr9", rdata0[31:0], 32'hDEAD_BEEF);
    @(negedge clk);
    we0 = 2'b00;
    #1 rst_n = 1'b1;
    #1;
    check("rst_rel_addr9", rdata0[31:0], 32'hDEAD_BEEF);
    check("rst_rel_addr5", rdata0[63:32], 32'hDEAD_BEEF);
    we0 = 2'b01; waddr0[4:0] = 5'd9; wdata0[31:0] = 32'h0000_00BB;
    tick();
    we0 = 2'b00;
    #1;
    check("post_rst_addr9", rdata0[31:0], 32'h0000_00BB);
    raddr0 = {5'd0, 5'd0};
    #1;
    check("post_rst_addr0", rdata0[63:32], 32'h0000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
